// File: rtl/dcache_pkg.sv
// Shared types and sizing for the data cache: FSM state encoding, default geometry, line width.
// No logic of its own; latency and backpressure are defined by data_cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWAP_OUT   = 2'd1,
    SWAP_IN    = 2'd2,
    SWAP_IN_OK = 2'd3
  } state_e;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_SET_ADDR_LEN  = 3;
  localparam int LINE_W            = 32 << DEF_LINE_ADDR_LEN;

  function automatic int line_width(input int line_addr_len);
    return 32 << line_addr_len;
  endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Per-set storage: line data, tag, valid and dirty; combinational read, clocked write, async clear.
// Zero read latency; a fill takes priority over a byte write in the same cycle; never stalls.
module dcache_line_ram #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_W         = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SET_ADDR_LEN-1:0]         rd_set,
  output logic [(32<<LINE_ADDR_LEN)-1:0]  rd_line,
  output logic [TAG_W-1:0]                rd_tag,
  output logic                            rd_valid,
  output logic                            rd_dirty,
  input  logic                            wr_en,
  input  logic [SET_ADDR_LEN-1:0]         wr_set,
  input  logic [LINE_ADDR_LEN-1:0]        wr_off,
  input  logic [3:0]                      wr_be,
  input  logic [31:0]                     wr_word,
  input  logic                            fill_en,
  input  logic [SET_ADDR_LEN-1:0]         fill_set,
  input  logic [TAG_W-1:0]                fill_tag,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]  fill_line
);

  localparam int SETS = 1 << SET_ADDR_LEN;
  localparam int LW   = 32 << LINE_ADDR_LEN;

  logic [LW-1:0]    data_mem [SETS];
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [SETS-1:0]  valid_bits;
  logic [SETS-1:0]  dirty_bits;

  assign rd_line  = data_mem[rd_set];
  assign rd_tag   = tag_mem[rd_set];
  assign rd_valid = valid_bits[rd_set];
  assign rd_dirty = dirty_bits[rd_set];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_en) begin
      data_mem[fill_set]   <= fill_line;
      tag_mem[fill_set]    <= fill_tag;
      valid_bits[fill_set] <= 1'b1;
      dirty_bits[fill_set] <= 1'b0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_mem[wr_set][(int'(wr_off) * 32) + (b * 8) +: 8] <= wr_word[b*8 +: 8];
        end
      end
      dirty_bits[wr_set] <= 1'b1;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache; hits answer combinationally, misses stall via miss.
// Refill blocks until mem_gnt; counters exist only when DCACHE_PERF_CNT_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_req,
  input  logic [3:0]                      wr_req,
  input  logic [31:0]                     addr,
  input  logic [31:0]                     wr_data,
  output logic [31:0]                     rd_data,
  output logic                            miss,
  output logic                            mem_rd_req,
  output logic                            mem_wr_req,
  output logic [31:0]                     mem_addr,
  output logic [(32<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
  input  logic                            mem_gnt,
  output logic [31:0]                     miss_count,
  output logic [31:0]                     hit_count
);

  localparam int TAG_W   = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LW      = 32 << LINE_ADDR_LEN;
  localparam int SET_LSB = LINE_ADDR_LEN + 2;
  localparam int TAG_LSB = LINE_ADDR_LEN + SET_ADDR_LEN + 2;

  logic [LINE_ADDR_LEN-1:0] offset;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_W-1:0]         tag;
  logic                     addr_unused;

  assign offset      = addr[LINE_ADDR_LEN+1:2];
  assign set_idx     = addr[SET_LSB +: SET_ADDR_LEN];
  assign tag         = addr[31:TAG_LSB];
  assign addr_unused = ^addr[1:0];

  state_e                   state_q;
  logic [SET_ADDR_LEN-1:0]  set_q;
  logic [TAG_W-1:0]         tag_q;
  logic [TAG_W-1:0]         victim_tag_q;
  logic [LW-1:0]            fill_q;

  logic [SET_ADDR_LEN-1:0]  rd_set;
  logic [LW-1:0]            rd_line;
  logic [TAG_W-1:0]         rd_tag;
  logic                     rd_valid;
  logic                     rd_dirty;
  logic                     req;
  logic                     hit;

  // Outside IDLE the arrays are addressed by the latched set so the victim line stays visible.
  assign rd_set = (state_q == IDLE) ? set_idx : set_q;

  dcache_line_ram #(
    .LINE_ADDR_LEN (LINE_ADDR_LEN),
    .SET_ADDR_LEN  (SET_ADDR_LEN),
    .TAG_W         (TAG_W)
  ) u_line_ram (
    .clk       (clk),
    .rst       (rst),
    .rd_set    (rd_set),
    .rd_line   (rd_line),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .wr_en     (hit & (|wr_req)),
    .wr_set    (set_idx),
    .wr_off    (offset),
    .wr_be     (wr_req),
    .wr_word   (wr_data),
    .fill_en   (state_q == SWAP_IN_OK),
    .fill_set  (set_q),
    .fill_tag  (tag_q),
    .fill_line (fill_q)
  );

  assign req         = rd_req | (|wr_req);
  assign hit         = (state_q == IDLE) & rd_valid & (rd_tag == tag);
  assign miss        = req & ~hit;
  assign rd_data     = rd_line[{offset, 5'b00000} +: 32];
  assign mem_wr_req  = (state_q == SWAP_OUT);
  assign mem_rd_req  = (state_q == SWAP_IN);
  assign mem_wr_line = rd_line;
  assign mem_addr    = {(state_q == SWAP_OUT) ? victim_tag_q : tag_q, set_q, {SET_LSB{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      set_q        <= '0;
      tag_q        <= '0;
      victim_tag_q <= '0;
      fill_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            set_q        <= set_idx;
            tag_q        <= tag;
            victim_tag_q <= rd_tag;
            state_q      <= (rd_valid & rd_dirty) ? SWAP_OUT : SWAP_IN;
          end
        end
        SWAP_OUT: begin
          if (mem_gnt) state_q <= SWAP_IN;
        end
        SWAP_IN: begin
          if (mem_gnt) begin
            fill_q  <= mem_rd_line;
            state_q <= SWAP_IN_OK;
          end
        end
        SWAP_IN_OK: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (req & hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) & miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Random and directed accesses against a flat-memory model plus a per-set tag/valid/dirty model.
// A memory responder answers fills and writebacks with random or fixed grant delays.
module tb_data_cache;
  import dcache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req;
  logic [3:0]        wr_req;
  logic [31:0]       addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              miss;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wr_line;
  logic [LINE_W-1:0] mem_rd_line;
  logic              mem_gnt;
  logic [31:0]       miss_count;
  logic [31:0]       hit_count;

  always #5 clk = ~clk;

  data_cache dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .miss        (miss),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_addr    (mem_addr),
    .mem_wr_line (mem_wr_line),
    .mem_rd_line (mem_rd_line),
    .mem_gnt     (mem_gnt),
    .miss_count  (miss_count),
    .hit_count   (hit_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural view: arch is what the CPU should read, dram is what memory actually holds.
  logic [31:0] dram [256];
  logic [31:0] arch [256];
  bit          mvalid [8];
  bit          mdirty [8];
  int          mtag   [8];
  int          mhit;
  int          mmiss;

  int          fixed_dly = 0;
  int          busy = 0;
  int          dly = 0;
  int          wb_cnt = 0;
  int          fill_cnt = 0;
  int          seq = 0;
  int          wb_seq = 0;
  int          fill_seq = 0;
  int          both_cnt = 0;
  logic [31:0] wb_addr = '0;
  logic [31:0] fill_addr = '0;
  logic [255:0] wb_line = '0;

  initial begin
    mem_gnt     = 1'b0;
    mem_rd_line = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      if (mem_rd_req && mem_wr_req) both_cnt++;
      if (mem_rd_req || mem_wr_req) begin
        if (busy == 0) begin
          busy = 1;
          dly  = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 4);
        end else if (dly > 1) begin
          dly--;
        end else begin
          if (mem_wr_req) begin
            for (int i = 0; i < 8; i++) dram[int'(mem_addr[9:2]) + i] = mem_wr_line[i*32 +: 32];
            wb_cnt++;
            wb_addr = mem_addr;
            wb_line = mem_wr_line;
            seq++;
            wb_seq = seq;
          end else begin
            for (int i = 0; i < 8; i++) mem_rd_line[i*32 +: 32] = dram[int'(mem_addr[9:2]) + i];
            fill_cnt++;
            fill_addr = mem_addr;
            seq++;
            fill_seq = seq;
          end
          mem_gnt = 1'b1;
          busy    = 0;
        end
      end else begin
        busy    = 0;
        mem_gnt = ($urandom_range(0, 5) == 0);
      end
    end
  end

  function automatic logic [31:0] exp_hits();
`ifdef DCACHE_PERF_CNT_EN
    return mhit;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef DCACHE_PERF_CNT_EN
    return mmiss;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = 0;
    end
    for (int i = 0; i < 256; i++) arch[i] = dram[i];
    mhit  = 0;
    mmiss = 0;
  endtask

  task automatic access(input logic rd, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    int w, s, t, wb0, fl0, cyc, vbase;
    bit ph, pdirty;
    logic [255:0] vline;
    w      = int'(a[9:2]);
    s      = int'(a[7:5]);
    t      = int'(a[31:8]);
    ph     = mvalid[s] && (mtag[s] == t);
    pdirty = mvalid[s] && mdirty[s];
    vbase  = mtag[s] * 64 + s * 8;
    for (int i = 0; i < 8; i++) vline[i*32 +: 32] = arch[vbase + i];
    wb0 = wb_cnt;
    fl0 = fill_cnt;
    @(posedge clk); #1;
    rd_req  = rd;
    wr_req  = be;
    addr    = a;
    wr_data = d;
    @(negedge clk);
    chk("miss_flag", miss, !ph);
    if (!ph) begin
      cyc = 0;
      while (miss === 1'b1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("miss_resolved", miss, 1'b0);
      chk("wb_count", wb_cnt - wb0, pdirty);
      chk("fill_count", fill_cnt - fl0, 1);
      chk("fill_addr", fill_addr, {a[31:5], 5'b0});
      if (pdirty) begin
        chk("wb_addr", wb_addr, (mtag[s] << 8) | (s << 5));
        chk("wb_line", wb_line, vline);
        chk("wb_before_fill", wb_seq < fill_seq, 1'b1);
      end
      mvalid[s] = 1'b1;
      mtag[s]   = t;
      mdirty[s] = 1'b0;
      mmiss++;
    end
    if (rd && be == 4'b0) chk("rd_data", rd_data, arch[w]);
    if (be != 4'b0) begin
      for (int b = 0; b < 4; b++) if (be[b]) arch[w][b*8 +: 8] = d[b*8 +: 8];
      mdirty[s] = 1'b1;
    end
    mhit++;
    @(posedge clk); #1;
    rd_req = 1'b0;
    wr_req = 4'b0;
    chk("hit_count", hit_count, exp_hits());
    chk("miss_count", miss_count, exp_misses());
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
  endfunction

  task automatic random_phase(input int n);
    int kind;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 3);
      if (kind < 2)       access(1'b1, 4'b0, rand_addr(), $urandom);
      else if (kind == 2) access(1'b0, 4'($urandom_range(1, 15)), rand_addr(), $urandom);
      else                access(1'b1, 4'($urandom_range(1, 15)), rand_addr(), $urandom);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] h0, m0;
    rst     = 1'b1;
    rd_req  = 1'b0;
    wr_req  = 4'b0;
    addr    = '0;
    wr_data = '0;
    for (int i = 0; i < 256; i++) dram[i] = $urandom;
    dram[9] = 32'h1122_3344;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_miss", miss, 1'b0);
    chk("rst_mem_rd_req", mem_rd_req, 1'b0);
    chk("rst_mem_wr_req", mem_wr_req, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr_line", mem_wr_line, '0);
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold read with a fixed four-cycle grant.
    fixed_dly = 4;
    access(1'b1, 4'b0, 32'h100, 32'h0);
    fixed_dly = 0;

    // Ten reads inside the filled line.
    h0 = hit_count;
    m0 = miss_count;
    for (int i = 0; i < 10; i++) access(1'b1, 4'b0, 32'h100 | (i % 8) << 2, 32'h0);
    chk("ten_hits", hit_count - h0, exp_hits() == 0 ? 32'd0 : 32'd10);
    chk("ten_no_miss", miss_count, m0);

    // Partial store into a line holding 0x11223344.
    access(1'b1, 4'b0, 32'h24, 32'h0);
    access(1'b0, 4'b0011, 32'h24, 32'hDEAD_BEEF);
    access(1'b1, 4'b0, 32'h24, 32'h0);
    chk("byte_merge", rd_data, 32'h1122_BEEF);

    // Dirty set 0 evicted by a conflicting tag.
    access(1'b0, 4'b1111, 32'h108, $urandom);
    access(1'b1, 4'b0, 32'h200, 32'h0);
    chk("evict_addr", wb_addr, 32'h100);

    random_phase(300);

    // Reset in the middle of a writeback.
    access(1'b0, 4'b1111, 32'h04C, $urandom);
    fixed_dly = 10;
    @(posedge clk); #1;
    rd_req = 1'b1;
    addr   = 32'h34C;
    cyc = 0;
    @(negedge clk);
    while (mem_wr_req !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("swap_out_seen", mem_wr_req, 1'b1);
    #2;
    rst    = 1'b1;
    rd_req = 1'b0;
    #1;
    chk("abort_mem_wr_req", mem_wr_req, 1'b0);
    chk("abort_mem_rd_req", mem_rd_req, 1'b0);
    chk("abort_miss", miss, 1'b0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_hit_count", hit_count, 32'h0);
    chk("abort_miss_count", miss_count, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    fixed_dly = 0;
    model_reset();
    access(1'b1, 4'b0, 32'h04C, 32'h0);

    random_phase(60);

    chk("rw_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
